// File: rtl/ula_pkg.sv
// ula_pkg: shared state encoding and select/mode constants for the nibble-serial ALU sequencer.
package ula_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0010;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_PASS_A = 4'b1111;
  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;
endpackage

// File: rtl/ula_nibble_sequencer.sv
// ula_nibble_sequencer: runs a WIDTH-bit op on one external 4-bit slice, LSB nibble first.
// Optional ULA_ZERO_FLAG_EN adds a registered zero flag for the assembled result.
module ula_nibble_sequencer
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             equal,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  input  logic             alu_a_eq_b
`ifdef ULA_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 4");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, result_nx;
  logic [3:0] s_q;
  logic m_q, carry_reg, eq_acc, last;
  logic [IW-1:0] idx;
  assign last = idx == IW'(NIBBLES - 1);
  assign carry = carry_reg;
  assign equal = eq_acc;
  always_comb begin
    state_nx = state;
    result_nx = result;
    result_nx[{idx, 2'b00} +: 4] = alu_f;
    busy = state != IDLE;
    done = state == DONE;
    alu_a = state == RUN ? a_q[{idx, 2'b00} +: 4] : '0;
    alu_b = state == RUN ? b_q[{idx, 2'b00} +: 4] : '0;
    alu_s = state == RUN ? s_q : '0;
    alu_m = state == RUN ? m_q : 1'b0;
    alu_cin = state == RUN ? carry_reg : 1'b0;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      m_q <= 1'b0;
      idx <= '0;
      carry_reg <= 1'b0;
      eq_acc <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_q <= op_a;
        b_q <= op_b;
        s_q <= op_s;
        m_q <= op_m;
        idx <= '0;
        carry_reg <= op_cin;
        eq_acc <= 1'b1;
      end else if (state == RUN) begin
        result <= result_nx;
        eq_acc <= eq_acc & alu_a_eq_b;
        // the slice ignores carry in logic mode, so the chain is forced to zero there
        carry_reg <= m_q == MODE_LOGIC ? 1'b0 : alu_cout;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
`ifdef ULA_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) zero <= 1'b0;
    else if (state == RUN && last) zero <= result_nx == '0;
  end
`endif
endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// tb_ula_nibble_sequencer: scoreboard bench with a behavioural 4-bit slice closing the loop.
module tb_ula_nibble_sequencer;
  import ula_pkg::*;
  localparam int NIB = 4;
  logic clk = 0, rst = 1, start = 0, op_m = 0, op_cin = 0;
  logic [3:0] op_s = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic busy, done, carry, equal, alu_m, alu_cin, alu_cout, alu_a_eq_b;
  logic [15:0] result;
  logic [3:0] alu_a, alu_b, alu_s, alu_f;
  logic [4:0] sum;
`ifdef ULA_ZERO_FLAG_EN
  logic zero;
`endif
  ula_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .carry(carry),
    .equal(equal), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout), .alu_a_eq_b(alu_a_eq_b)
`ifdef ULA_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );
  always #5 clk = ~clk;
  always_comb begin
    sum = alu_s == S_SUB ? {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cin)
                         : {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
    alu_f = alu_m ? (alu_s == S_XOR ? alu_a ^ alu_b : alu_s == S_PASS_A ? alu_a : 4'h0) : sum[3:0];
    alu_cout = alu_m ? 1'b0 : sum[4];
    alu_a_eq_b = alu_a == alu_b;
  end
  typedef struct {
    logic [15:0] r;
    logic c, e, z;
    int t0;
    string name;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, passes = 0;
  always @(posedge clk) cyc++;
  function void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endfunction
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk({x.name, "_result"}, result, x.r);
        chk({x.name, "_carry"}, carry, x.c);
        chk({x.name, "_equal"}, equal, x.e);
        chk({x.name, "_latency"}, cyc - x.t0, NIB);
`ifdef ULA_ZERO_FLAG_EN
        chk({x.name, "_zero"}, zero, x.z);
`endif
      end
    end
  end
  task automatic drive(input logic [3:0] s, input logic m, input logic cin,
                       input logic [15:0] a, input logic [15:0] b);
    op_s = s; op_m = m; op_cin = cin; op_a = a; op_b = b; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle(input string n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk({n, "_timeout"}, 1, 0);
  endtask
  task automatic issue(input string n, input logic [3:0] s, input logic m, input logic cin,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic c, input logic e, input logic w);
    sb.push_back('{r: r, c: c, e: e, z: r == 16'h0, t0: cyc + 1, name: n});
    drive(s, m, cin, a, b);
    if (w) wait_idle(n);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_equal", equal, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
    issue("add", S_ADD, MODE_ARITH, 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 1);
    issue("add_ovf", S_ADD, MODE_ARITH, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
    issue("sub_nb", S_SUB, MODE_ARITH, 1, 16'h5000, 16'h1000, 16'h4000, 1, 0, 1);
    issue("sub_b", S_SUB, MODE_ARITH, 1, 16'h1000, 16'h5000, 16'hC000, 0, 0, 1);
    issue("xor", S_XOR, MODE_LOGIC, 1, 16'hAAAA, 16'h5555, 16'hFFFF, 0, 0, 1);
    issue("pass_eq", S_PASS_A, MODE_LOGIC, 0, 16'h3C3C, 16'h3C3C, 16'h3C3C, 0, 1, 1);
    issue("pass_ne", S_PASS_A, MODE_LOGIC, 0, 16'h3C3C, 16'h3C3D, 16'h3C3C, 0, 0, 1);
    issue("busy_ign", S_ADD, MODE_ARITH, 0, 16'h0101, 16'h0202, 16'h0303, 0, 0, 0);
    chk("busy_in_run", busy, 1);
    drive(S_SUB, MODE_ARITH, 1, 16'hFFFF, 16'hFFFF);
    wait_idle("busy_ign");
    drive(S_ADD, MODE_ARITH, 0, 16'h1111, 16'h2222);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_carry", carry, 0);
    chk("midrst_equal", equal, 0);
    chk("midrst_alu", {alu_a, alu_b, alu_cin}, 0);
    repeat (8) @(negedge clk);
    issue("after_rst", S_ADD, MODE_ARITH, 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
